mpeg_video_header_encoder: RTL and testbench

MPEG_VIDEO_HEADER_ENCODER -- requirements
Module: mpeg_video_header_encoder

---
 rtl/mpeg_video_header_encoder.sv | 222 ++++++++++++++++++++++
 tb/tb_mpeg_video_header_encoder.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mpeg_video_header_encoder.sv
// mpeg_video_header_encoder
// Serialises MPEG-1 video headers (sequence, GOP, picture, sequence end) into
// a byte stream with a valid/ready handshake on both sides.
//   - A command is accepted only when the encoder is idle. Its fields are then
//     packed into a left-aligned 8-byte payload register, so later changes on
//     the command inputs cannot disturb the header in flight.
//   - Output order: start-code prefix 00 00 01, the code byte, then the
//     payload bytes (none for a sequence end).
//   - Optional build macro MPEG_HDR_SEQ_END_EN: when defined, cmd_type 3 emits
//     00 00 01 B7. When undefined, cmd_type 3 is accepted and dropped.
module mpeg_video_header_encoder (
    input  logic        clk,
    input  logic        reset_n,
    // command side
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_type,
    // sequence header fields
    input  logic [11:0] hsize,
    input  logic [11:0] vsize,
    input  logic [3:0]  aspect,
    input  logic [3:0]  rate,
    input  logic [17:0] bitrate,
    input  logic [9:0]  vbv_size,
    input  logic        constrained,
    // GOP fields
    input  logic        drop,
    input  logic [4:0]  hours,
    input  logic [5:0]  minutes,
    input  logic [5:0]  seconds,
    input  logic [5:0]  pictures,
    input  logic        closed_gop,
    input  logic        broken_link,
    // picture fields
    input  logic [9:0]  tmpref,
    input  logic [2:0]  pic_type,
    input  logic [15:0] vbv_delay,
    // stream side
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PREFIX  = 2'd1,
        CODE    = 2'd2,
        PAYLOAD = 2'd3
    } state_t;

    state_t          state, state_nxt;
    logic [2:0]      cnt;          // byte index inside PREFIX or PAYLOAD
    logic            cnt_clr, cnt_inc;
    logic            init_q;       // keeps cmd_ready low until the first edge after reset
    logic            cmd_fire;

    // Latched copy of the accepted command
    logic [7:0]      code_q;
    logic [7:0][7:0] payload_q;    // [7] is sent first
    logic [2:0]      last_idx_q;   // index of the final payload byte

    // Next-command assembly from the live inputs
    logic [7:0]      code_d;
    logic [7:0][7:0] payload_d;
    logic [2:0]      last_idx_d;
    logic [2:0]      eff_pic_type;

`ifdef MPEG_HDR_SEQ_END_EN
    logic            is_end_q;     // header is a bare sequence end code
`endif

    assign cmd_fire = cmd_valid & cmd_ready;

    // Pack the command fields into the on-wire bit layout, MSB first
    always_comb begin
        // Illegal picture types are coded as I pictures so the stream stays legal
        eff_pic_type = (pic_type == 3'd2 || pic_type == 3'd3) ? pic_type : 3'd1;
        code_d       = 8'hB7;
        payload_d    = '0;
        last_idx_d   = 3'd0;
        case (cmd_type)
            2'd0: begin
                code_d     = 8'hB3;
                payload_d  = {hsize, vsize, aspect, rate, bitrate, 1'b1,
                              vbv_size, constrained, 2'b00};
                last_idx_d = 3'd7;
            end
            2'd1: begin
                code_d     = 8'hB8;
                payload_d  = {drop, hours, minutes, 1'b1, seconds, pictures,
                              closed_gop, broken_link, 5'b00000, 32'h0};
                last_idx_d = 3'd3;
            end
            2'd2: begin
                code_d = 8'h00;
                case (eff_pic_type)
                    3'd2: begin
                        // full_pel 0, forward f_code 001, extra 0, 6-bit pad
                        payload_d  = {tmpref, eff_pic_type, vbv_delay,
                                      1'b0, 3'b001, 1'b0, 6'b000000, 24'h0};
                        last_idx_d = 3'd4;
                    end
                    3'd3: begin
                        // forward and backward 0+001, extra 0, 2-bit pad
                        payload_d  = {tmpref, eff_pic_type, vbv_delay,
                                      4'b0001, 4'b0001, 1'b0, 2'b00, 24'h0};
                        last_idx_d = 3'd4;
                    end
                    default: begin
                        // I picture: extra 0, 2-bit pad
                        payload_d  = {tmpref, eff_pic_type, vbv_delay,
                                      1'b0, 2'b00, 32'h0};
                        last_idx_d = 3'd3;
                    end
                endcase
            end
            default: begin
                code_d = 8'hB7;
            end
        endcase
    end

    // Capture the packed command on acceptance
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            code_q     <= 8'h00;
            payload_q  <= '0;
            last_idx_q <= 3'd0;
`ifdef MPEG_HDR_SEQ_END_EN
            is_end_q   <= 1'b0;
`endif
        end else if (cmd_fire) begin
            code_q     <= code_d;
            payload_q  <= payload_d;
            last_idx_q <= last_idx_d;
`ifdef MPEG_HDR_SEQ_END_EN
            is_end_q   <= (cmd_type == 2'd3);
`endif
        end
    end

    // Ready gate: low throughout reset, high from the first edge after release
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) init_q <= 1'b0;
        else          init_q <= 1'b1;
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Byte counter shared by the prefix and payload phases
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)     cnt <= 3'd0;
        else if (cnt_clr) cnt <= 3'd0;
        else if (cnt_inc) cnt <= cnt + 3'd1;
    end

    // Next-state and output decode
    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        out_valid = 1'b0;
        out_data  = 8'h00;
        out_last  = 1'b0;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = init_q;
                if (cmd_valid && init_q) begin
`ifdef MPEG_HDR_SEQ_END_EN
                    state_nxt = PREFIX;
`else
                    // a sequence end is swallowed without leaving IDLE
                    if (cmd_type != 2'd3) state_nxt = PREFIX;
`endif
                end
            end
            PREFIX: begin
                out_valid = 1'b1;
                out_data  = (cnt == 3'd2) ? 8'h01 : 8'h00;
                if (out_ready) begin
                    if (cnt == 3'd2) begin
                        cnt_clr   = 1'b1;
                        state_nxt = CODE;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            CODE: begin
                out_valid = 1'b1;
                out_data  = code_q;
`ifdef MPEG_HDR_SEQ_END_EN
                out_last  = is_end_q;
                if (out_ready) state_nxt = is_end_q ? IDLE : PAYLOAD;
`else
                if (out_ready) state_nxt = PAYLOAD;
`endif
            end
            PAYLOAD: begin
                out_valid = 1'b1;
                out_data  = payload_q[3'd7 - cnt];
                out_last  = (cnt == last_idx_q);
                if (out_ready) begin
                    if (cnt == last_idx_q) begin
                        cnt_clr   = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mpeg_video_header_encoder.sv
// Testbench for mpeg_video_header_encoder: fixed vectors with known byte
// streams, hand-written reset/stall sequences, and random commands checked
// against a bitstream model that concatenates fields and packs them to bytes.
module tb_mpeg_video_header_encoder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_type;
    logic [11:0] hsize, vsize;
    logic [3:0]  aspect, rate;
    logic [17:0] bitrate;
    logic [9:0]  vbv_size;
    logic        constrained;
    logic        drop;
    logic [4:0]  hours;
    logic [5:0]  minutes, seconds, pictures;
    logic        closed_gop, broken_link;
    logic [9:0]  tmpref;
    logic [2:0]  pic_type;
    logic [15:0] vbv_delay;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;

    always #5 clk = ~clk;

    mpeg_video_header_encoder dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
        .hsize(hsize), .vsize(vsize), .aspect(aspect), .rate(rate),
        .bitrate(bitrate), .vbv_size(vbv_size), .constrained(constrained),
        .drop(drop), .hours(hours), .minutes(minutes), .seconds(seconds),
        .pictures(pictures), .closed_gop(closed_gop), .broken_link(broken_link),
        .tmpref(tmpref), .pic_type(pic_type), .vbv_delay(vbv_delay),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last)
    );

    typedef struct {
        logic [1:0]  t;
        logic [11:0] hs, vs;
        logic [3:0]  asp, rt;
        logic [17:0] br;
        logic [9:0]  vbv;
        logic        con, drp;
        logic [4:0]  hr;
        logic [5:0]  mn, sc, pc;
        logic        cg, bl;
        logic [9:0]  tr;
        logic [2:0]  pt;
        logic [15:0] vd;
    } cmd_t;

    typedef struct {
        cmd_t        c;
        int          n;      // expected byte count
        logic [95:0] exp;    // expected bytes, left-aligned
        int          mode;   // 0 ready high, 1 random ready, 2 stall 3 cycles at byte 5
    } vec_t;

    int          total = 0;
    int          bad   = 0;
    logic [7:0]  exp_q[$];
    bit          bits_q[$];

    task automatic chk(input logic [63:0] got, input logic [63:0] want, input string name);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic apply(input cmd_t c);
        cmd_type = c.t;   hsize = c.hs;   vsize = c.vs;   aspect = c.asp;
        rate = c.rt;      bitrate = c.br; vbv_size = c.vbv; constrained = c.con;
        drop = c.drp;     hours = c.hr;   minutes = c.mn; seconds = c.sc;
        pictures = c.pc;  closed_gop = c.cg; broken_link = c.bl;
        tmpref = c.tr;    pic_type = c.pt; vbv_delay = c.vd;
    endtask

    function automatic cmd_t rand_cmd();
        cmd_t c;
        c.t = 2'($urandom_range(0, 3));
        c.hs = 12'($urandom); c.vs = 12'($urandom); c.asp = 4'($urandom);
        c.rt = 4'($urandom);  c.br = 18'($urandom); c.vbv = 10'($urandom);
        c.con = 1'($urandom); c.drp = 1'($urandom); c.hr = 5'($urandom);
        c.mn = 6'($urandom);  c.sc = 6'($urandom);  c.pc = 6'($urandom);
        c.cg = 1'($urandom);  c.bl = 1'($urandom);  c.tr = 10'($urandom);
        c.pt = 3'($urandom);  c.vd = 16'($urandom);
        return c;
    endfunction

    // Reference model: append fields to a bit list, then cut into bytes
    task automatic put(input logic [31:0] v, input int w);
        for (int i = w - 1; i >= 0; i--) bits_q.push_back(v[i]);
    endtask

    task automatic build_exp(input cmd_t c);
        logic [2:0] ptc;
        logic [7:0] b;
        exp_q.delete();
        bits_q.delete();
        if (c.t == 2'd3) begin
`ifdef MPEG_HDR_SEQ_END_EN
            put(32'h000001B7, 32);
`endif
        end else begin
            put(32'h000001, 24);
            if (c.t == 2'd0) begin
                put(32'hB3, 8); put(c.hs, 12); put(c.vs, 12); put(c.asp, 4);
                put(c.rt, 4); put(c.br, 18); put(1, 1); put(c.vbv, 10);
                put(c.con, 1); put(0, 2);
            end else if (c.t == 2'd1) begin
                put(32'hB8, 8); put(c.drp, 1); put(c.hr, 5); put(c.mn, 6);
                put(1, 1); put(c.sc, 6); put(c.pc, 6); put(c.cg, 1);
                put(c.bl, 1); put(0, 5);
            end else begin
                ptc = (c.pt == 3'd2 || c.pt == 3'd3) ? c.pt : 3'd1;
                put(32'h00, 8); put(c.tr, 10); put(ptc, 3); put(c.vd, 16);
                if (ptc == 3'd2) begin
                    put(0, 1); put(1, 3); put(0, 1); put(0, 6);
                end else if (ptc == 3'd3) begin
                    put(1, 4); put(1, 4); put(0, 1); put(0, 2);
                end else begin
                    put(0, 1); put(0, 2);
                end
            end
        end
        while (bits_q.size() >= 8) begin
            b = 8'h00;
            for (int k = 0; k < 8; k++) b = {b[6:0], bits_q.pop_front()};
            exp_q.push_back(b);
        end
    endtask

    // Present a command at a negedge and wait (bounded) for acceptance.
    // Returns at the negedge after acceptance with the inputs scrambled.
    task automatic issue(input cmd_t c, input string tag);
        int w;
        apply(c);
        cmd_valid = 1'b1;
        w = 0;
        while (!cmd_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (w >= 50) begin
            chk(0, 1, {tag, " accept timeout"});
        end
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        apply(rand_cmd());
    endtask

    // Issue a command and compare the emitted bytes against exp_q
    task automatic run_cmd(input cmd_t c, input int mode, input string tag);
        int         idx, cyc, stall;
        logic       held, rdy;
        logic [7:0] hdata;
        logic       hlast;
        issue(c, tag);
        if (exp_q.size() == 0) begin
            chk(cmd_ready, 1, {tag, " ready after drop"});
            chk(out_valid, 0, {tag, " no output"});
            @(negedge clk);
            chk(out_valid, 0, {tag, " no output later"});
            return;
        end
        chk(out_valid, 1, {tag, " first byte latency"});
        idx = 0; cyc = 0; stall = 0; held = 1'b0; hdata = 8'h00; hlast = 1'b0;
        while (idx < exp_q.size() && cyc < 200) begin
            if (held) begin
                chk({out_valid, out_last, out_data}, {1'b1, hlast, hdata},
                    $sformatf("%s hold byte%0d", tag, idx));
            end
            if (mode == 1)                    rdy = 1'($urandom_range(0, 2) != 0);
            else if (mode == 2 && idx == 5 && stall < 3) begin
                rdy = 1'b0;
                stall++;
            end else                          rdy = 1'b1;
            out_ready = rdy;
            if (out_valid && rdy) begin
                chk(out_data, exp_q[idx], $sformatf("%s byte%0d", tag, idx));
                chk(out_last, (idx == exp_q.size() - 1), $sformatf("%s last%0d", tag, idx));
                idx++;
            end
            held  = out_valid && !rdy;
            hdata = out_data;
            hlast = out_last;
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 200) chk(idx, exp_q.size(), {tag, " byte timeout"});
        if (mode == 0) chk(cyc, exp_q.size(), {tag, " throughput"});
        if (mode == 2) chk(stall, 3, {tag, " stall applied"});
        chk({out_valid, cmd_ready}, 2'b01, {tag, " idle after last"});
    endtask

    task automatic load_exp(input vec_t v);
        logic [95:0] w;
        exp_q.delete();
        w = v.exp;
        for (int i = 0; i < v.n; i++) exp_q.push_back(w[95 - 8*i -: 8]);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[9];
        cmd_t z, g;
        z = '{default: '0};

        // GOP 0,1,2,3,4 closed, not broken
        vecs[0].c = z; vecs[0].c.t = 2'd1; vecs[0].c.hr = 5'd1; vecs[0].c.mn = 6'd2;
        vecs[0].c.sc = 6'd3; vecs[0].c.pc = 6'd4; vecs[0].c.cg = 1'b1;
        vecs[0].n = 8; vecs[0].exp = {64'h000001B804286240, 32'h0}; vecs[0].mode = 0;
        // I picture tmpref 5 vbv FFFF
        vecs[1].c = z; vecs[1].c.t = 2'd2; vecs[1].c.tr = 10'd5; vecs[1].c.pt = 3'd1;
        vecs[1].c.vd = 16'hFFFF;
        vecs[1].n = 8; vecs[1].exp = {64'h00000100014FFFF8, 32'h0}; vecs[1].mode = 0;
        // P picture all zero
        vecs[2].c = z; vecs[2].c.t = 2'd2; vecs[2].c.pt = 3'd2;
        vecs[2].n = 9; vecs[2].exp = {72'h000001000010000080, 24'h0}; vecs[2].mode = 0;
        // sequence header 352x240
        vecs[3].c = z; vecs[3].c.t = 2'd0; vecs[3].c.hs = 12'd352; vecs[3].c.vs = 12'd240;
        vecs[3].c.asp = 4'd1; vecs[3].c.rt = 4'd3; vecs[3].c.br = 18'h3FFFF;
        vecs[3].c.vbv = 10'd20; vecs[3].c.con = 1'b1;
        vecs[3].n = 12; vecs[3].exp = 96'h000001B31600F013FFFFE0A4; vecs[3].mode = 0;
        // same sequence header, sink stalls 3 cycles at byte 5
        vecs[4] = vecs[3]; vecs[4].mode = 2;
        // B picture tmpref 3FF vbv 1234, random sink
        vecs[5].c = z; vecs[5].c.t = 2'd2; vecs[5].c.tr = 10'h3FF; vecs[5].c.pt = 3'd3;
        vecs[5].c.vd = 16'h1234;
        vecs[5].n = 9; vecs[5].exp = {72'h00000100FFD891A088, 24'h0}; vecs[5].mode = 1;
        // pic_type 0 coded as I
        vecs[6].c = z; vecs[6].c.t = 2'd2; vecs[6].c.pt = 3'd0;
        vecs[6].n = 8; vecs[6].exp = {64'h0000010000080000, 32'h0}; vecs[6].mode = 0;
        // pic_type 7 coded as I
        vecs[7].c = z; vecs[7].c.t = 2'd2; vecs[7].c.pt = 3'd7; vecs[7].c.tr = 10'd5;
        vecs[7].c.vd = 16'hFFFF;
        vecs[7].n = 8; vecs[7].exp = {64'h00000100014FFFF8, 32'h0}; vecs[7].mode = 0;
        // sequence end
        vecs[8].c = z; vecs[8].c.t = 2'd3; vecs[8].mode = 0;
`ifdef MPEG_HDR_SEQ_END_EN
        vecs[8].n = 4; vecs[8].exp = {32'h000001B7, 64'h0};
`else
        vecs[8].n = 0; vecs[8].exp = 96'h0;
`endif

        // reset state
        reset_n = 1'b0; cmd_valid = 1'b0; out_ready = 1'b1;
        apply(z);
        repeat (3) @(negedge clk);
        chk({cmd_ready, out_valid, out_last, out_data}, 11'h0, "reset outputs");
        reset_n = 1'b1;
        @(negedge clk);
        chk({cmd_ready, out_valid}, 2'b10, "ready after reset");

        // fixed vectors
        for (int i = 0; i < 9; i++) begin
            load_exp(vecs[i]);
            run_cmd(vecs[i].c, vecs[i].mode, $sformatf("vec%0d", i));
        end

        // reset pulsed mid-GOP
        g = vecs[0].c;
        out_ready = 1'b1;
        issue(g, "rst_gop");
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b0;
        #1 chk({cmd_ready, out_valid, out_last, out_data}, 11'h0, "async reset mid header");
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk({cmd_ready, out_valid}, 2'b10, "ready after mid reset");
        load_exp(vecs[0]);
        run_cmd(g, 0, "gop after reset");

        // random commands against the model
        for (int i = 0; i < 60; i++) begin
            cmd_t c;
            c = rand_cmd();
            build_exp(c);
            run_cmd(c, int'($urandom_range(0, 1)), $sformatf("rnd%0d t%0d", i, c.t));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
